seq_mag_compare: RTL and testbench



---
 rtl/seq_mag_compare.sv | 119 +++++++++++
 tb/tb_seq_mag_compare.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_compare.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands SLICE bits per
// clock, most-significant slice first, stopping at the first unequal slice.
module seq_mag_compare #(
  parameter  int WIDTH  = 16,
  parameter  int SLICE  = 4,
  localparam int NSLICE = WIDTH / SLICE,
  localparam int CW     = $clog2(NSLICE) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             aeb,
  output logic             agb,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("seq_mag_compare: WIDTH must be a positive multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;

  // Returns {a_gt_b, a_lt_b} for one slice. Flipping the sign bit of both slices
  // maps two's-complement ordering onto unsigned ordering.
  function automatic logic [1:0] slice_cmp(input logic [SLICE-1:0] sa,
                                           input logic [SLICE-1:0] sb,
                                           input logic             flip);
    logic [SLICE-1:0] xa;
    logic [SLICE-1:0] xb;
    xa = sa;
    xb = sb;
    if (flip) begin
      xa[SLICE-1] = ~xa[SLICE-1];
      xb[SLICE-1] = ~xb[SLICE-1];
    end
    return {(xa > xb), (xa < xb)};
  endfunction

  // Stage p0: current slice and its comparison result
  logic [SLICE-1:0] sa_p0;
  logic [SLICE-1:0] sb_p0;
  logic             flip_p0;
  logic [1:0]       res_p0;

  always_comb begin
    sa_p0   = a_q[idx*SLICE +: SLICE];
    sb_p0   = b_q[idx*SLICE +: SLICE];
    flip_p0 = sm_q && (idx == IW'(NSLICE - 1));
    res_p0  = slice_cmp(sa_p0, sb_p0, flip_p0);
  end

  // Stage p1: control FSM and registered result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sm_q   <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      alb    <= 1'b0;
      aeb    <= 1'b0;
      agb    <= 1'b0;
      cycles <= '0;
    end else begin
      done <= 1'b0;
      if ((state != CMP) && start) begin
        a_q   <= a;
        b_q   <= b;
        sm_q  <= signed_mode;
        idx   <= IW'(NSLICE - 1);
        cnt   <= '0;
        alb   <= 1'b0;
        aeb   <= 1'b0;
        agb   <= 1'b0;
        busy  <= 1'b1;
        state <= CMP;
      end else if (state == CMP) begin
        if (res_p0 != 2'b00) begin
          agb    <= res_p0[1];
          alb    <= res_p0[0];
          cycles <= cnt + CW'(1);
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end else if (idx == '0) begin
          aeb    <= 1'b1;
          cycles <= CW'(NSLICE);
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end else begin
          idx <= idx - IW'(1);
          cnt <= cnt + CW'(1);
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_seq_mag_compare.sv
// Self-checking bench for seq_mag_compare: directed cases from the compare rules
// plus randomized operands against an arithmetic reference model.
module tb_seq_mag_compare;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             alb;
  logic             aeb;
  logic             agb;
  logic [CW-1:0]    cycles;

  int tests = 0;
  int fails = 0;

  seq_mag_compare #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done),
    .alb(alb), .aeb(aeb), .agb(agb), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: ordering from plain signed/unsigned arithmetic; slices examined from
  // the position of the highest differing bit.
  task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sm,
                       output logic lt, output logic eq, output logic gt, output int cyc);
    logic [WIDTH-1:0] d;
    int p;
    d  = x ^ y;
    eq = (d == '0);
    lt = sm ? ($signed(x) < $signed(y)) : (x < y);
    gt = !lt && !eq;
    p  = -1;
    for (int i = 0; i < WIDTH; i++) if (d[i]) p = i;
    cyc = eq ? NSLICE : NSLICE - (p / SLICE);
  endtask

  // Waits for done after an accepted start; returns the latency (0 on timeout).
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    for (int k = 1; k <= NSLICE + 2; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      check({tag, ".busy_mid"}, busy, 1'b1);
    end
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] x,
                              input logic [WIDTH-1:0] y, input logic sm, input int lat);
    logic lt, eq, gt;
    int cyc;
    model(x, y, sm, lt, eq, gt, cyc);
    check({tag, ".latency"}, lat, cyc);
    check({tag, ".flags"}, {alb, aeb, agb}, {lt, eq, gt});
    check({tag, ".cycles"}, cycles, cyc);
    check({tag, ".busy_done"}, busy, 1'b0);
  endtask

  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic sm);
    int lat;
    @(negedge clk);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_e0"}, {busy, done}, 2'b10);
    wait_done(tag, lat);
    check_result(tag, x, y, sm, lat);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] rx, ry;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outputs", {busy, done, alb, aeb, agb}, 5'b0);
    check("reset.cycles", cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle.no_start", {busy, done}, 2'b00);

    // Directed cases
    run_cmp("eq_u", 16'h1234, 16'h1234, 1'b0);
    run_cmp("ms_u", 16'h8000, 16'h7FFF, 1'b0);
    run_cmp("ms_s", 16'h8000, 16'h7FFF, 1'b1);
    run_cmp("deep_u", 16'h12F4, 16'h12F5, 1'b0);
    run_cmp("mid_u", 16'h1300, 16'h12FF, 1'b0);
    run_cmp("low_s", 16'hFFFE, 16'hFFFF, 1'b1);
    run_cmp("neg_pos_s", 16'hFFFF, 16'h0001, 1'b1);
    run_cmp("pos_neg_s", 16'h0001, 16'hFFFF, 1'b1);
    run_cmp("neg_pos_u", 16'hFFFF, 16'h0001, 1'b0);

    // Start held with operands moving during the compare, then back-to-back start
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("held.busy_e0", busy, 1'b1);
    lat = 0;
    for (int k = 1; k <= NSLICE + 2; k++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = 1'($urandom);
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check_result("held", 16'h1234, 16'h1234, 1'b0, lat);
    a = 16'h0005; b = 16'h0003; signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.busy_e0", {busy, done}, 2'b10);
    check("b2b.flags_cleared", {alb, aeb, agb}, 3'b000);
    wait_done("b2b", lat);
    check_result("b2b", 16'h0005, 16'h0003, 1'b0, lat);

    // Reset mid-compare
    @(negedge clk);
    a = 16'h4321; b = 16'h4321; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs", {busy, done, alb, aeb, agb}, 5'b0);
    check("rst_mid.cycles", cycles, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_mid.no_done", {busy, done}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp("after_rst", 16'h0000, 16'h0000, 1'b0);

    // Randomized compares; half share upper slices to reach deeper decisions
    for (int n = 0; n < 40; n++) begin
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      if (n % 2 == 1) ry = (rx & ~WIDTH'((1 << ($urandom_range(0, WIDTH - 1))) - 1)) |
                           (ry & WIDTH'((1 << ($urandom_range(0, WIDTH - 1))) - 1));
      if (n % 7 == 3) ry = rx;
      run_cmp($sformatf("rand%0d", n), rx, ry, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
